// File: rtl/xbar_switch_n_if.sv
// xbar_switch_n_if: source/sink handshake bundle of the N-port crossbar
interface xbar_switch_n_if #(
  parameter int AW_DEV = 2,
  parameter int N_PORT = 4,
  parameter int DW     = 4,
  parameter int DEPTH  = 2
);
  logic [N_PORT-1:0]           validtx_i, acktx_o, validrx_o, ackrx_i, full_o;
  logic [N_PORT*AW_DEV-1:0]    adr_i;
  logic [N_PORT*DW-1:0]        dat_i, dat_o;
  logic [N_PORT*(DEPTH+1)-1:0] count_o;
  logic                        adr_err_o;
  modport master (output validtx_i, adr_i, dat_i, ackrx_i,
                  input  acktx_o, validrx_o, dat_o, full_o, count_o, adr_err_o);
  modport slave  (input  validtx_i, adr_i, dat_i, ackrx_i,
                  output acktx_o, validrx_o, dat_o, full_o, count_o, adr_err_o);
endinterface

// File: rtl/xbar_switch_n.sv
// xbar_switch_n: N-port crossbar with a round-robin arbiter and FWFT FIFO per destination
module xbar_switch_n #(
  parameter int AW_DEV = 2,
  parameter int N_PORT = 4,
  parameter int DW     = 4,
  parameter int DEPTH  = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  xbar_switch_n_if.slave bus
);
  localparam int N_ENT = 1 << DEPTH;
  localparam logic [DEPTH:0] FULL = (DEPTH+1)'(N_ENT);
  logic [DW-1:0]     mem [N_PORT][N_ENT];
  logic [DEPTH-1:0]  wr_ptr [N_PORT];
  logic [DEPTH-1:0]  rd_ptr [N_PORT];
  logic [DEPTH:0]    cnt [N_PORT];
  logic [AW_DEV-1:0] ptr [N_PORT];
  logic [AW_DEV-1:0] src [N_PORT];
  logic [N_PORT-1:0] push, pop, bad;
  logic              adr_err;

  function automatic int rr_idx(logic [AW_DEV-1:0] base, int k);
    return (int'(base) + k) % N_PORT;
  endfunction

  // Round-robin grant per destination starting after its last winner; a full FIFO only accepts alongside a pop
  always_comb begin
    push = '0;
    bad  = '0;
    pop  = '0;
    for (int p = 0; p < N_PORT; p++)
      bad[p] = bus.validtx_i[p] && int'(bus.adr_i[p*AW_DEV +: AW_DEV]) >= N_PORT;
    for (int d = 0; d < N_PORT; d++) begin
      src[d] = '0;
      pop[d] = cnt[d] != '0 && bus.ackrx_i[d];
      for (int k = 1; k <= N_PORT; k++)
        if (!push[d] && (cnt[d] != FULL || pop[d]) && bus.validtx_i[rr_idx(ptr[d], k)] &&
            int'(bus.adr_i[rr_idx(ptr[d], k)*AW_DEV +: AW_DEV]) == d) begin
          push[d] = 1'b1;
          src[d]  = AW_DEV'(rr_idx(ptr[d], k));
        end
    end
  end

  // FIFO pointers, occupancy, arbiter history and the dropped-address pulse
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int d = 0; d < N_PORT; d++) begin
        ptr[d]    <= AW_DEV'(N_PORT - 1);
        wr_ptr[d] <= '0;
        rd_ptr[d] <= '0;
        cnt[d]    <= '0;
      end
      adr_err <= 1'b0;
    end else begin
      for (int d = 0; d < N_PORT; d++) begin
        if (push[d]) begin
          ptr[d]    <= src[d];
          wr_ptr[d] <= wr_ptr[d] + DEPTH'(1);
        end
        if (pop[d]) rd_ptr[d] <= rd_ptr[d] + DEPTH'(1);
        cnt[d] <= cnt[d] + (DEPTH+1)'(push[d]) - (DEPTH+1)'(pop[d]);
      end
      adr_err <= |bad;
    end

  // Storage carries no reset so it can map onto plain RAM; stale words are masked by empty state
  always_ff @(posedge clk_i)
    for (int d = 0; d < N_PORT; d++)
      if (push[d]) mem[d][wr_ptr[d]] <= bus.dat_i[int'(src[d])*DW +: DW];

  // Source acks, FIFO status and first-word-fall-through heads
  always_comb begin
    bus.acktx_o = bad;
    for (int d = 0; d < N_PORT; d++)
      for (int p = 0; p < N_PORT; p++)
        if (push[d] && int'(src[d]) == p) bus.acktx_o[p] = 1'b1;
    if (rst_i) bus.acktx_o = '0;
    for (int d = 0; d < N_PORT; d++) begin
      bus.validrx_o[d]                    = cnt[d] != '0;
      bus.full_o[d]                       = cnt[d] == FULL;
      bus.count_o[d*(DEPTH+1) +: DEPTH+1] = cnt[d];
      bus.dat_o[d*DW +: DW]               = cnt[d] != '0 ? mem[d][rd_ptr[d]] : '0;
    end
    bus.adr_err_o = adr_err;
  end
endmodule

// File: tb/tb_xbar_switch_n.sv
// tb_xbar_switch_n: directed checks of the crossbar on a 4-port and a 3-port instance
module tb_xbar_switch_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int failed = 0;
  int total = 0;
  logic [3:0] rr_ack [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
  logic [3:0] rr_dat [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h1, 4'h2};

  always #5 clk = ~clk;

  xbar_switch_n_if #(.AW_DEV(2), .N_PORT(4), .DW(4), .DEPTH(2)) a();
  xbar_switch_n_if #(.AW_DEV(2), .N_PORT(3), .DW(4), .DEPTH(2)) b();

  xbar_switch_n #(.AW_DEV(2), .N_PORT(4), .DW(4), .DEPTH(2)) dut_a (.clk_i(clk), .rst_i(rst), .bus(a.slave));
  xbar_switch_n #(.AW_DEV(2), .N_PORT(3), .DW(4), .DEPTH(2)) dut_b (.clk_i(clk), .rst_i(rst), .bus(b.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    a.validtx_i = 4'b1111; a.adr_i = '0; a.dat_i = '0; a.ackrx_i = '0;
    b.validtx_i = '0;      b.adr_i = '0; b.dat_i = '0; b.ackrx_i = '0;
    #12;
    chk("rst_ack", 32'(a.acktx_o), 0);
    chk("rst_validrx", 32'(a.validrx_o), 0);
    chk("rst_count", 32'(a.count_o), 0);
    chk("rst_full", 32'(a.full_o), 0);
    chk("rst_dat", 32'(a.dat_o), 0);
    chk("rst_err", 32'(a.adr_err_o), 0);
    a.validtx_i = '0;
    cyc;
    rst = 1'b0;
    // single transfer src1 -> dest2
    a.validtx_i = 4'b0010; a.adr_i = 8'h08; a.dat_i = 16'h00A0;
    #1;
    chk("t1_ack", 32'(a.acktx_o), 32'b0010);
    chk("t1_pre_valid", 32'(a.validrx_o), 0);
    cyc;
    a.validtx_i = '0;
    #1;
    chk("t1_validrx", 32'(a.validrx_o), 32'b0100);
    chk("t1_dat", 32'(a.dat_o[8 +: 4]), 32'hA);
    chk("t1_count", 32'(a.count_o[6 +: 3]), 1);
    a.ackrx_i = 4'b0100;
    cyc;
    a.ackrx_i = '0;
    #1;
    chk("t1_count_after_pop", 32'(a.count_o[6 +: 3]), 0);
    chk("t1_validrx_after_pop", 32'(a.validrx_o), 0);
    // round robin: srcs 0,1,3 -> dest0 with continuous pop
    a.adr_i = 8'h00; a.dat_i = 16'h3021; a.validtx_i = 4'b1011; a.ackrx_i = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr_ack%0d", i), 32'(a.acktx_o), 32'(rr_ack[i]));
      if (i > 0) chk($sformatf("rr_dat%0d", i), 32'(a.dat_o[3:0]), 32'(rr_dat[i]));
      cyc;
    end
    a.validtx_i = '0;
    #1;
    chk("rr_dat_last", 32'(a.dat_o[3:0]), 3);
    chk("rr_valid_last", 32'(a.validrx_o[0]), 1);
    cyc;
    a.ackrx_i = '0;
    #1;
    chk("rr_drained", 32'(a.count_o[2:0]), 0);
    // full/backpressure: src0 -> dest1, no pops
    a.adr_i = 8'h01; a.validtx_i = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      a.dat_i = 16'(5 + i);
      #1;
      chk($sformatf("full_ack%0d", i), 32'(a.acktx_o), 1);
      cyc;
    end
    a.dat_i = 16'h0009;
    #1;
    chk("full_flag", 32'(a.full_o), 32'b0010);
    chk("full_count", 32'(a.count_o[3 +: 3]), 4);
    chk("full_stall", 32'(a.acktx_o), 0);
    cyc;
    chk("full_stall2", 32'(a.acktx_o), 0);
    a.ackrx_i = 4'b0010;
    #1;
    chk("full_push_pop_ack", 32'(a.acktx_o), 1);
    cyc;
    a.ackrx_i = '0; a.validtx_i = '0;
    #1;
    chk("full_count_kept", 32'(a.count_o[3 +: 3]), 4);
    chk("full_flag_kept", 32'(a.full_o), 32'b0010);
    a.ackrx_i = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_dat%0d", i), 32'(a.dat_o[4 +: 4]), 32'(6 + i));
      cyc;
    end
    a.ackrx_i = '0;
    #1;
    chk("drain_count", 32'(a.count_o[3 +: 3]), 0);
    // parallel: src0 -> dest3, src2 -> dest1
    a.adr_i = 8'h13; a.dat_i = 16'h0D0C; a.validtx_i = 4'b0101;
    #1;
    chk("par_ack", 32'(a.acktx_o), 32'b0101);
    cyc;
    a.validtx_i = '0;
    #1;
    chk("par_validrx", 32'(a.validrx_o), 32'b1010);
    chk("par_dat3", 32'(a.dat_o[12 +: 4]), 32'hC);
    chk("par_dat1", 32'(a.dat_o[4 +: 4]), 32'hD);
    a.ackrx_i = 4'b1010;
    cyc;
    a.ackrx_i = '0;
    // out-of-range address on the 3-port instance
    b.adr_i = 6'b110000; b.validtx_i = 3'b100;
    #1;
    chk("bad_ack", 32'(b.acktx_o), 32'b100);
    chk("bad_err_before", 32'(b.adr_err_o), 0);
    cyc;
    b.validtx_i = '0;
    #1;
    chk("bad_err_pulse", 32'(b.adr_err_o), 1);
    chk("bad_validrx", 32'(b.validrx_o), 0);
    chk("bad_count", 32'(b.count_o), 0);
    cyc;
    chk("bad_err_cleared", 32'(b.adr_err_o), 0);
    // reset mid-operation
    a.adr_i = 8'h00; a.validtx_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      a.dat_i = 16'(i + 1);
      #1;
      chk($sformatf("fill_ack%0d", i), 32'(a.acktx_o), 1);
      cyc;
    end
    a.validtx_i = '0;
    #1;
    chk("fill_count", 32'(a.count_o[2:0]), 3);
    #1;
    rst = 1'b1;
    a.validtx_i = 4'b0011; a.dat_i = 16'h00FE;
    #1;
    chk("mid_rst_validrx", 32'(a.validrx_o), 0);
    chk("mid_rst_count", 32'(a.count_o), 0);
    chk("mid_rst_ack", 32'(a.acktx_o), 0);
    chk("mid_rst_dat", 32'(a.dat_o), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_priority", 32'(a.acktx_o), 32'b0001);
    cyc;
    a.validtx_i = '0;
    #1;
    chk("post_rst_validrx", 32'(a.validrx_o), 32'b0001);
    chk("post_rst_dat", 32'(a.dat_o[3:0]), 32'hE);
    chk("post_rst_count", 32'(a.count_o[2:0]), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/xbar_switch_n.md
Name: xbar_switch_n

Overview:
- Parametrised single-clock N-port crossbar switch; successor to the fixed 4-port, two-sided switch.
- Each of N_PORT source ports sends DW-bit words tagged with a destination address.
- Each destination owns a FIFO of 2^DEPTH entries, fed through a per-destination round-robin arbiter.
- Sits between N_PORT producer/consumer device pairs using the valid/ack handshake; sources and sinks are decoupled by the FIFOs.

Parameters:
- AW_DEV, 2, address width of destination field.
- N_PORT, 4, number of source and destination ports (2..1<<AW_DEV).
- DW, 4, data width.
- DEPTH, 2, log2 of FIFO entries per destination (entries = 1<<DEPTH).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- validtx_i  in  N_PORT  source p has a word to send; held until acktx_o[p].
- adr_i  in  N_PORT*AW_DEV  destination of source p, slice [p*AW_DEV +: AW_DEV].
- dat_i  in  N_PORT*DW  payload of source p, slice [p*DW +: DW].
- acktx_o  out  N_PORT  combinational; word of source p is accepted at this clock edge.
- validrx_o  out  N_PORT  destination FIFO d non-empty.
- dat_o  out  N_PORT*DW  head word of FIFO d (first-word-fall-through).
- ackrx_i  in  N_PORT  sink d consumes head at this edge.
- full_o  out  N_PORT  FIFO d holds 1<<DEPTH words.
- count_o  out  N_PORT*(DEPTH+1)  occupancy of FIFO d.
- adr_err_o  out  1  registered one-cycle pulse; an out-of-range address was dropped.

Behaviour:
- Reset (async, rst_i=1):
  - all FIFOs empty; validrx_o=0, full_o=0, count_o=0, dat_o=0, adr_err_o=0.
  - acktx_o=0 while rst_i is high.
  - all RR pointers = N_PORT-1, so source 0 has top priority first.
- Requests: source p requests destination d when validtx_i[p]=1 and adr_i[p]==d, with d<N_PORT.
- Out-of-range address (adr_i[p]>=N_PORT, valid):
  - acktx_o[p]=1 and the word is discarded.
  - adr_err_o=1 on the next cycle.
  - these requests never enter arbitration.
- Arbitration per destination d:
  - Combinational round-robin among requesting sources.
  - Search starts at ptr[d]+1 and wraps modulo N_PORT.
  - Exactly one grant per destination per cycle.
  - Grant allowed if !full[d], or if full[d] && validrx_o[d] && ackrx_i[d] (push and pop in the same cycle).
  - On a grant, ptr[d] <= granted index; otherwise ptr[d] is held.
- A source requests exactly one destination, so at most one grant per source; acktx_o[p] = OR of its grants.
- Push: on the edge where acktx_o[p]=1, dat_i[p] is written at wr_ptr[d], and wr_ptr increments, wrapping at 1<<DEPTH.
- Pop: ackrx_i[d] with validrx_o[d]=1 advances rd_ptr[d]. ackrx_i[d] while empty is ignored with no state change.
- Latency: a word accepted at edge k appears on validrx_o/dat_o after edge k, so minimum source-to-sink latency is 1 cycle.
- Occupancy: count_o[d] changes by +1 (push only), -1 (pop only), or 0 (both or neither). It never exceeds 1<<DEPTH and never underflows.
- Ordering: words from one source to one destination are delivered in acceptance order.
- Contention for a full FIFO with no pop: every requester stalls with acktx_o=0 and ptr is held.
- Sources must hold adr_i/dat_i stable while validtx_i=1 and acktx_o=0. Changing them is allowed but undefined for fairness.
- Reset asserted mid-transfer: all FIFO contents are lost and no acks are issued. After reset deasserts, operation resumes from the empty state on the next edge.

Test Plan:
- Single transfer: N_PORT=4. Src1 sends adr=2, dat=4'hA. Expect acktx_o=4'b0010 the same cycle, then validrx_o[2]=1, dat_o[2]=A and count_o[2]=1 one cycle later; ackrx_i[2] pulse returns count to 0.
- Round-robin: srcs 0,1,3 all target dest 0 continuously with ackrx_i[0]=1. Grants must occur in order 0,1,3,0,1,3. Received data order must match.
- Full/backpressure: DEPTH=2, ackrx_i[1]=0. Src0 sends 5 words to dest 1. First 4 are acked, then full_o[1]=1 and the 5th stalls. Pulse ackrx_i[1] once; the 5th is acked in that same cycle and count stays 4.
- Parallel non-conflicting: src0->dest3 and src2->dest1 in the same cycle. Both acked the same cycle and both delivered 1 cycle later.
- Bad address: N_PORT=3, src2 sends adr=3. Expect acktx_o[2]=1, no FIFO change, and adr_err_o=1 for exactly one cycle.
- Reset mid-operation: fill dest0 with 3 words, then assert rst_i asynchronously between edges. Outputs must clear immediately (validrx_o=0, count_o=0); after release, a new word has 1-cycle latency and src0 has priority.
